// File: rtl/i2s_pkg.sv
// Shared constants, state type and helpers for the I2S receive path.
// LRCK polarity, default frame geometry and the receiver state encoding live here.
package i2s_pkg;

    localparam logic LEFT_CHANNEL  = 1'b1;
    localparam logic RIGHT_CHANNEL = 1'b0;

    localparam int DEFAULT_DATA_WIDTH  = 24;
    localparam int DEFAULT_SLOT_WIDTH  = 32;
    localparam int DEFAULT_SYNC_STAGES = 2;

    localparam int               BIT_CNT_WIDTH = 6;
    localparam logic [BIT_CNT_WIDTH-1:0] BIT_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        LEFT,
        RIGHT
    } rxState_t;

    // Slot bit counter stops at its maximum so a runaway slot cannot wrap back to a legal length.
    function automatic logic [BIT_CNT_WIDTH-1:0] satIncrement(input logic [BIT_CNT_WIDTH-1:0] value);
        if (value == BIT_CNT_MAX) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Brings BCK/LRCK/DIN into the CLK_AUDIO domain and reports registered BCK edges
// together with the LRCK and DIN values taken from the same synchroniser stage.
module i2s_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_AUDIO,
    input  logic nRST,
    input  logic bck_i,
    input  logic lrck_i,
    input  logic din_i,
    output logic bckRise_o,
    output logic bckFall_o,
    output logic lrck_o,
    output logic din_o
);

    logic [SYNC_STAGES-1:0] bckSync_q;
    logic [SYNC_STAGES-1:0] lrckSync_q;
    logic [SYNC_STAGES-1:0] dinSync_q;
    logic                   bckHist_q;
    logic                   bckRise_q;
    logic                   bckFall_q;
    logic                   lrck_q;
    logic                   din_q;

    // Edge outputs and data samples are registered together so they stay cycle-aligned.
    always_ff @(posedge CLK_AUDIO or negedge nRST) begin
        if (!nRST) begin
            bckSync_q  <= '0;
            lrckSync_q <= '0;
            dinSync_q  <= '0;
            bckHist_q  <= 1'b0;
            bckRise_q  <= 1'b0;
            bckFall_q  <= 1'b0;
            lrck_q     <= 1'b0;
            din_q      <= 1'b0;
        end else begin
            bckSync_q[0]  <= bck_i;
            lrckSync_q[0] <= lrck_i;
            dinSync_q[0]  <= din_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                bckSync_q[i]  <= bckSync_q[i-1];
                lrckSync_q[i] <= lrckSync_q[i-1];
                dinSync_q[i]  <= dinSync_q[i-1];
            end
            bckHist_q <= bckSync_q[SYNC_STAGES-1];
            bckRise_q <= bckSync_q[SYNC_STAGES-1] & ~bckHist_q;
            bckFall_q <= ~bckSync_q[SYNC_STAGES-1] & bckHist_q;
            lrck_q    <= lrckSync_q[SYNC_STAGES-1];
            din_q     <= dinSync_q[SYNC_STAGES-1];
        end
    end

    assign bckRise_o = bckRise_q;
    assign bckFall_o = bckFall_q;
    assign lrck_o    = lrck_q;
    assign din_o     = din_q;

endmodule

// File: rtl/i2s_receive.sv
// Slave I2S receiver: oversamples BCK/LRCK/DIN, deserialises left-justified MSB-first
// samples into stereo pairs and flags slots whose length is not SLOT_WIDTH.
module i2s_receive
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SLOT_WIDTH  = DEFAULT_SLOT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                  CLK_AUDIO,
    input  logic                  nRST,
    input  logic                  enable,
    input  logic                  BCK_IN,
    input  logic                  LRCK_IN,
    input  logic                  DIN,
    output logic [DATA_WIDTH-1:0] left_audio_out,
    output logic [DATA_WIDTH-1:0] right_audio_out,
    output logic                  sample_valid,
    output logic                  frame_error
);

    localparam logic [BIT_CNT_WIDTH-1:0] CNT_DATA      = BIT_CNT_WIDTH'(DATA_WIDTH);
    localparam logic [BIT_CNT_WIDTH-1:0] CNT_LAST_DATA = BIT_CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_WIDTH-1:0] CNT_SLOT      = BIT_CNT_WIDTH'(SLOT_WIDTH);

    logic bckRise;
    logic bckFall;
    logic lrckSample;
    logic dinSample;

    i2s_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .CLK_AUDIO(CLK_AUDIO),
        .nRST     (nRST),
        .bck_i    (BCK_IN),
        .lrck_i   (LRCK_IN),
        .din_i    (DIN),
        .bckRise_o(bckRise),
        .bckFall_o(bckFall),
        .lrck_o   (lrckSample),
        .din_o    (dinSample)
    );

    rxState_t                 state_q,       state_d;
    logic [BIT_CNT_WIDTH-1:0] bitCnt_q,      bitCnt_d;
    logic [DATA_WIDTH-1:0]    leftShift_q,   leftShift_d;
    logic [DATA_WIDTH-1:0]    rightShift_q,  rightShift_d;
    logic [DATA_WIDTH-1:0]    leftOut_q,     leftOut_d;
    logic [DATA_WIDTH-1:0]    rightOut_q,    rightOut_d;
    logic                     sampleValid_q, sampleValid_d;
    logic                     frameError_q,  frameError_d;
    logic                     commit_q,      commit_d;
    logic                     frameBad_q,    frameBad_d;
    logic                     lrckPrev_q,    lrckPrev_d;
    logic                     havePrev_q,    havePrev_d;
    logic                     armed_q,       armed_d;

    logic                     bitEdge;
    logic                     slotStart;
    logic                     slotLenOk;
    logic                     captureBit;
    logic [DATA_WIDTH-1:0]    leftShifted;
    logic [DATA_WIDTH-1:0]    rightShifted;

    // A BCK already high when reset releases is not a real edge, so a fall must arm the next rise.
    assign bitEdge      = bckRise & armed_q;
    assign slotStart    = bitEdge & havePrev_q & (lrckSample != lrckPrev_q);
    assign slotLenOk    = (bitCnt_q == CNT_SLOT);
    assign captureBit   = (bitCnt_q < CNT_DATA);
    assign leftShifted  = {leftShift_q[DATA_WIDTH-2:0], dinSample};
    assign rightShifted = {rightShift_q[DATA_WIDTH-2:0], dinSample};

    always_comb begin
        state_d       = state_q;
        bitCnt_d      = bitCnt_q;
        leftShift_d   = leftShift_q;
        rightShift_d  = rightShift_q;
        leftOut_d     = leftOut_q;
        rightOut_d    = rightOut_q;
        sampleValid_d = 1'b0;
        frameError_d  = 1'b0;
        commit_d      = 1'b0;
        frameBad_d    = frameBad_q;
        lrckPrev_d    = lrckPrev_q;
        havePrev_d    = havePrev_q;
        armed_d       = armed_q;

        if (bckRise) begin
            armed_d = 1'b0;
        end else if (bckFall) begin
            armed_d = 1'b1;
        end

        if (bitEdge) begin
            lrckPrev_d = lrckSample;
            havePrev_d = 1'b1;
        end

        if (!enable) begin
            state_d      = IDLE;
            bitCnt_d     = '0;
            leftShift_d  = '0;
            rightShift_d = '0;
            frameBad_d   = 1'b0;
        end else begin
            if (commit_q) begin
                leftOut_d     = leftShift_q;
                rightOut_d    = rightShift_q;
                sampleValid_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    state_d  = SEEK;
                    bitCnt_d = '0;
                end

                SEEK: begin
                    if (slotStart && (lrckSample == LEFT_CHANNEL)) begin
                        state_d     = LEFT;
                        bitCnt_d    = 1;
                        leftShift_d = leftShifted;
                        frameBad_d  = 1'b0;
                    end
                end

                LEFT: begin
                    if (slotStart) begin
                        frameError_d = ~slotLenOk;
                        frameBad_d   = ~slotLenOk;
                        state_d      = RIGHT;
                        bitCnt_d     = 1;
                        rightShift_d = rightShifted;
                    end else if (bitEdge) begin
                        if (captureBit) begin
                            leftShift_d = leftShifted;
                        end
                        bitCnt_d = satIncrement(bitCnt_q);
                    end
                end

                RIGHT: begin
                    if (slotStart) begin
                        frameError_d = ~slotLenOk;
                        frameBad_d   = 1'b0;
                        state_d      = LEFT;
                        bitCnt_d     = 1;
                        leftShift_d  = leftShifted;
                    end else if (bitEdge) begin
                        if (captureBit) begin
                            rightShift_d = rightShifted;
                        end
                        if ((bitCnt_q == CNT_LAST_DATA) && !frameBad_q) begin
                            commit_d = 1'b1;
                        end
                        bitCnt_d = satIncrement(bitCnt_q);
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_AUDIO or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            bitCnt_q      <= '0;
            leftShift_q   <= '0;
            rightShift_q  <= '0;
            leftOut_q     <= '0;
            rightOut_q    <= '0;
            sampleValid_q <= 1'b0;
            frameError_q  <= 1'b0;
            commit_q      <= 1'b0;
            frameBad_q    <= 1'b0;
            lrckPrev_q    <= 1'b0;
            havePrev_q    <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            bitCnt_q      <= bitCnt_d;
            leftShift_q   <= leftShift_d;
            rightShift_q  <= rightShift_d;
            leftOut_q     <= leftOut_d;
            rightOut_q    <= rightOut_d;
            sampleValid_q <= sampleValid_d;
            frameError_q  <= frameError_d;
            commit_q      <= commit_d;
            frameBad_q    <= frameBad_d;
            lrckPrev_q    <= lrckPrev_d;
            havePrev_q    <= havePrev_d;
            armed_q       <= armed_d;
        end
    end

    assign left_audio_out  = leftOut_q;
    assign right_audio_out = rightOut_q;
    assign sample_valid    = sampleValid_q;
    assign frame_error     = frameError_q;

endmodule
